// File: rtl/fixed_point_expand_if.sv
// Stream, control and status bundle for fixed_point_expand.
// master = upstream/downstream environment, slave = the expander itself.
interface fixed_point_expand_if #(
  parameter int WIDTH_IN  = 8,
  parameter int WIDTH_OUT = 16,
  parameter int SHIFT_W   = 4,
  parameter int CNT_W     = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH_IN-1:0]  din;
  logic [SHIFT_W-1:0]   shift;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH_OUT-1:0] dout;
  logic                 sat_out;
  logic                 sat_flag;
  logic [CNT_W-1:0]     sat_count;
  logic                 clr;

  modport master (
    output in_valid, din, shift, out_ready, clr,
    input  in_ready, out_valid, dout, sat_out, sat_flag, sat_count
  );

  modport slave (
    input  in_valid, din, shift, out_ready, clr,
    output in_ready, out_valid, dout, sat_out, sat_flag, sat_count
  );
endinterface

// File: rtl/fixed_point_expand.sv
// Streaming fixed-point widener: extend, shift left by a runtime amount,
// saturate to WIDTH_OUT, and register the result behind a valid/ready stage.
module fixed_point_expand #(
  parameter int WIDTH_IN  = 8,
  parameter int WIDTH_OUT = 16,
  parameter int IS_SIGNED = 1,
  parameter int SHIFT_W   = 4,
  parameter int CNT_W     = 16
) (
  input logic                clk,
  input logic                rst,
  fixed_point_expand_if.slave bus
);

  // Wide enough that no shift amount can push a bit off the top before the range check.
  localparam int EXT_W = WIDTH_OUT + (1 << SHIFT_W);

  localparam logic [WIDTH_OUT-1:0] POS_SAT  = {1'b0, {(WIDTH_OUT-1){1'b1}}};
  localparam logic [WIDTH_OUT-1:0] NEG_SAT  = {1'b1, {(WIDTH_OUT-1){1'b0}}};
  localparam logic [WIDTH_OUT-1:0] ALL_ONES = '1;

  if (WIDTH_IN <= 0 || WIDTH_OUT < WIDTH_IN) begin : g_param_check
    $error("fixed_point_expand: need WIDTH_IN > 0 and WIDTH_OUT >= WIDTH_IN");
  end

  logic                 r_out_valid;
  logic [WIDTH_OUT-1:0] r_dout;
  logic                 r_sat_out;
  logic                 r_sat_flag;
  logic [CNT_W-1:0]     r_sat_count;

  logic                 w_in_ready;
  logic                 w_accept;
  logic                 w_sign;
  logic [EXT_W-1:0]     w_ext;
  logic [EXT_W-1:0]     w_shifted;
  logic [WIDTH_OUT-1:0] w_result;
  logic                 w_sat;

  assign w_in_ready = !r_out_valid || bus.out_ready;
  assign w_accept   = bus.in_valid && w_in_ready;

  assign w_sign    = (IS_SIGNED != 0) && bus.din[WIDTH_IN-1];
  assign w_ext     = {{(EXT_W-WIDTH_IN){w_sign}}, bus.din};
  assign w_shifted = w_ext << bus.shift;

  // Range check on the full-width shifted value, then pick the clamp value.
  always_comb begin
    w_result = w_shifted[WIDTH_OUT-1:0];
    w_sat    = 1'b0;
    if (IS_SIGNED != 0) begin
      // In range only if every bit from WIDTH_OUT-1 upward matches the sign.
      if (!((w_shifted[EXT_W-1:WIDTH_OUT-1] == '0) ||
            (w_shifted[EXT_W-1:WIDTH_OUT-1] == '1))) begin
        w_sat    = 1'b1;
        w_result = w_shifted[EXT_W-1] ? NEG_SAT : POS_SAT;
      end
    end else begin
      if (w_shifted[EXT_W-1:WIDTH_OUT] != '0) begin
        w_sat    = 1'b1;
        w_result = ALL_ONES;
      end
    end
  end

  // Output pipeline register: load on accept, drain on ready, otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_dout      <= '0;
      r_sat_out   <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_dout      <= w_result;
      r_sat_out   <= w_sat;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Sticky saturation flag and clamped event counter; clear has priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sat_flag  <= 1'b0;
      r_sat_count <= '0;
    end else if (bus.clr) begin
      r_sat_flag  <= 1'b0;
      r_sat_count <= '0;
    end else if (w_accept && w_sat) begin
      r_sat_flag <= 1'b1;
      if (r_sat_count != '1) begin
        r_sat_count <= r_sat_count + CNT_W'(1);
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.dout      = r_dout;
  assign bus.sat_out   = r_sat_out;
  assign bus.sat_flag  = r_sat_flag;
  assign bus.sat_count = r_sat_count;

endmodule

// File: tb/tb_fixed_point_expand.sv
// Self-checking bench: signed 8->12 (2-bit counter) and unsigned 8->12 instances.
module tb_fixed_point_expand;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fixed_point_expand_if #(.WIDTH_IN(8), .WIDTH_OUT(12), .SHIFT_W(4), .CNT_W(2))  bs ();
  fixed_point_expand_if #(.WIDTH_IN(8), .WIDTH_OUT(12), .SHIFT_W(4), .CNT_W(16)) bu ();

  fixed_point_expand #(.WIDTH_IN(8), .WIDTH_OUT(12), .IS_SIGNED(1), .SHIFT_W(4), .CNT_W(2))
    dut_s (.clk(clk), .rst(rst), .bus(bs));
  fixed_point_expand #(.WIDTH_IN(8), .WIDTH_OUT(12), .IS_SIGNED(0), .SHIFT_W(4), .CNT_W(16))
    dut_u (.clk(clk), .rst(rst), .bus(bu));

  int total = 0;
  int bad   = 0;

  // Stream model state for the signed instance.
  bit         m_valid = 1'b0;
  logic [15:0] m_q = '0;
  bit         m_sat = 1'b0;
  bit         m_flag = 1'b0;
  int         m_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Plain integer arithmetic: value * 2^shift, then clamp to the output range.
  function automatic void ref_model(input bit sgn, input int wo, input logic [7:0] d,
                                    input int sh, output logic [15:0] q, output bit sat);
    longint v, lo, hi, mask;
    v    = sgn ? longint'($signed(d)) : longint'(d);
    v    = v * (longint'(1) << sh);
    mask = (longint'(1) << wo) - 1;
    if (sgn) begin
      hi = (longint'(1) << (wo - 1)) - 1;
      lo = -(longint'(1) << (wo - 1));
    end else begin
      hi = mask;
      lo = 0;
    end
    sat = 1'b0;
    if (v > hi) begin v = hi; sat = 1'b1; end
    else if (v < lo) begin v = lo; sat = 1'b1; end
    q = 16'(v & mask);
  endfunction

  task automatic beat_s(input logic [7:0] d, input logic [3:0] sh, input logic c);
    bs.in_valid = 1'b1; bs.din = d; bs.shift = sh; bs.clr = c; bs.out_ready = 1'b1;
    @(posedge clk); #1;
    bs.in_valid = 1'b0; bs.clr = 1'b0;
  endtask

  task automatic beat_u(input logic [7:0] d, input logic [3:0] sh);
    bu.in_valid = 1'b1; bu.din = d; bu.shift = sh; bu.out_ready = 1'b1;
    @(posedge clk); #1;
    bu.in_valid = 1'b0;
  endtask

  // Ten random beats through the signed instance; full=1 keeps both sides busy.
  task automatic stream(input bit full, input string tag);
    logic [7:0] vd [10];
    logic [3:0] vs [10];
    int idx = 0, deliv = 0, cyc = 0;
    bit exp_rdy, acc;
    for (int i = 0; i < 10; i++) begin
      vd[i] = 8'($urandom);
      vs[i] = 4'($urandom_range(0, 15));
    end
    while ((idx < 10 || m_valid) && cyc < 300) begin
      cyc++;
      bs.out_ready = full ? 1'b1 : 1'($urandom_range(0, 1));
      bs.in_valid  = (idx < 10) ? (full ? 1'b1 : ($urandom_range(0, 3) != 0)) : 1'b0;
      if (idx < 10) begin
        bs.din = vd[idx]; bs.shift = vs[idx];
      end
      #1;
      exp_rdy = !m_valid || bs.out_ready;
      chk({tag, " in_ready"}, 32'(bs.in_ready), 32'(exp_rdy));
      chk({tag, " out_valid"}, 32'(bs.out_valid), 32'(m_valid));
      if (m_valid) begin
        chk({tag, " dout"}, 32'(bs.dout), 32'(m_q));
        chk({tag, " sat_out"}, 32'(bs.sat_out), 32'(m_sat));
      end
      chk({tag, " sat_count"}, 32'(bs.sat_count), 32'(m_cnt));
      chk({tag, " sat_flag"}, 32'(bs.sat_flag), 32'(m_flag));
      if (m_valid && bs.out_ready) deliv++;
      acc = bs.in_valid && exp_rdy;
      @(posedge clk); #1;
      if (acc) begin
        ref_model(1'b1, 12, vd[idx], int'(vs[idx]), m_q, m_sat);
        m_valid = 1'b1;
        if (m_sat) begin
          m_flag = 1'b1;
          if (m_cnt < 3) m_cnt++;
        end
        idx++;
      end else if (bs.out_ready) begin
        m_valid = 1'b0;
      end
    end
    bs.in_valid = 1'b0;
    chk({tag, " within cycle budget"}, 32'(cyc < 300), 32'd1);
    chk({tag, " beats delivered"}, 32'(deliv), 32'd10);
    if (full) chk({tag, " cycles at full rate"}, 32'(cyc), 32'd11);
  endtask

  initial begin
    logic [15:0] q;
    bit          s;
    logic [7:0]  d;
    logic [3:0]  sh;
    int          ucnt;

    bs.in_valid = 1'b0; bs.din = '0; bs.shift = '0; bs.out_ready = 1'b0; bs.clr = 1'b0;
    bu.in_valid = 1'b0; bu.din = '0; bu.shift = '0; bu.out_ready = 1'b0; bu.clr = 1'b0;

    // Reset state, checked while reset is held
    #12;
    chk("rst in_ready", 32'(bs.in_ready), 32'd1);
    chk("rst out_valid", 32'(bs.out_valid), 32'd0);
    chk("rst dout", 32'(bs.dout), 32'd0);
    chk("rst sat_flag", 32'(bs.sat_flag), 32'd0);
    chk("rst sat_count", 32'(bs.sat_count), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Signed 8->12 edges
    beat_s(8'h7F, 4'd4, 1'b0);
    chk("s 7F<<4 dout", 32'(bs.dout), 32'h7F0);
    chk("s 7F<<4 sat", 32'(bs.sat_out), 32'd0);
    chk("s 7F<<4 valid", 32'(bs.out_valid), 32'd1);
    beat_s(8'h7F, 4'd5, 1'b0);
    chk("s 7F<<5 dout", 32'(bs.dout), 32'h7FF);
    chk("s 7F<<5 sat", 32'(bs.sat_out), 32'd1);
    chk("s 7F<<5 count", 32'(bs.sat_count), 32'd1);
    chk("s 7F<<5 flag", 32'(bs.sat_flag), 32'd1);
    beat_s(8'h80, 4'd4, 1'b0);
    chk("s 80<<4 dout", 32'(bs.dout), 32'h800);
    chk("s 80<<4 sat", 32'(bs.sat_out), 32'd0);
    beat_s(8'h80, 4'd5, 1'b0);
    chk("s 80<<5 dout", 32'(bs.dout), 32'h800);
    chk("s 80<<5 sat", 32'(bs.sat_out), 32'd1);
    beat_s(8'hFF, 4'd15, 1'b0);
    chk("s FF<<15 dout", 32'(bs.dout), 32'h800);
    chk("s FF<<15 sat", 32'(bs.sat_out), 32'd1);
    chk("s count 3", 32'(bs.sat_count), 32'd3);
    beat_s(8'h00, 4'd15, 1'b0);
    chk("s 00<<15 dout", 32'(bs.dout), 32'd0);
    chk("s 00<<15 sat", 32'(bs.sat_out), 32'd0);
    beat_s(8'h7F, 4'd15, 1'b0);
    beat_s(8'h80, 4'd15, 1'b0);
    chk("s count held", 32'(bs.sat_count), 32'd3);

    // Clear beats a same-cycle saturating accept
    beat_s(8'h7F, 4'd5, 1'b1);
    chk("clr count", 32'(bs.sat_count), 32'd0);
    chk("clr flag", 32'(bs.sat_flag), 32'd0);
    chk("clr beat sat_out", 32'(bs.sat_out), 32'd1);
    chk("clr beat dout", 32'(bs.dout), 32'h7FF);

    // Unsigned 8->12
    beat_u(8'hFF, 4'd4);
    chk("u FF<<4 dout", 32'(bu.dout), 32'hFF0);
    chk("u FF<<4 sat", 32'(bu.sat_out), 32'd0);
    beat_u(8'hFF, 4'd5);
    chk("u FF<<5 dout", 32'(bu.dout), 32'hFFF);
    chk("u FF<<5 sat", 32'(bu.sat_out), 32'd1);
    beat_u(8'h01, 4'd11);
    chk("u 01<<11 dout", 32'(bu.dout), 32'h800);
    chk("u 01<<11 sat", 32'(bu.sat_out), 32'd0);
    beat_u(8'h01, 4'd12);
    chk("u 01<<12 dout", 32'(bu.dout), 32'hFFF);
    chk("u 01<<12 sat", 32'(bu.sat_out), 32'd1);
    chk("u count", 32'(bu.sat_count), 32'd2);

    // Random sweep of both instances against the arithmetic model
    ucnt = 2;
    for (int i = 0; i < 30; i++) begin
      d  = 8'($urandom);
      sh = 4'($urandom_range(0, 15));
      beat_u(d, sh);
      ref_model(1'b0, 12, d, int'(sh), q, s);
      if (s) ucnt++;
      chk("u rand dout", 32'(bu.dout), 32'(q[11:0]));
      chk("u rand sat", 32'(bu.sat_out), 32'(s));
      beat_s(d, sh, 1'b0);
      ref_model(1'b1, 12, d, int'(sh), q, s);
      chk("s rand dout", 32'(bs.dout), 32'(q[11:0]));
      chk("s rand sat", 32'(bs.sat_out), 32'(s));
    end
    chk("u rand count", 32'(bu.sat_count), 32'(ucnt));

    // Backpressure and full-rate streams from a cleared counter
    bs.clr = 1'b1; bs.out_ready = 1'b1;
    @(posedge clk); #1;
    bs.clr = 1'b0;
    m_valid = 1'b0; m_flag = 1'b0; m_cnt = 0;
    stream(1'b0, "bp");
    stream(1'b0, "bp2");
    stream(1'b1, "full");

    // Asynchronous reset while a saturated beat is stalled
    bs.out_ready = 1'b0; bs.in_valid = 1'b1; bs.din = 8'h7F; bs.shift = 4'd15;
    @(posedge clk); #1;
    bs.in_valid = 1'b0;
    chk("pre-rst valid", 32'(bs.out_valid), 32'd1);
    chk("pre-rst dout", 32'(bs.dout), 32'h7FF);
    chk("pre-rst flag", 32'(bs.sat_flag), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async out_valid", 32'(bs.out_valid), 32'd0);
    chk("async dout", 32'(bs.dout), 32'd0);
    chk("async sat_out", 32'(bs.sat_out), 32'd0);
    chk("async sat_flag", 32'(bs.sat_flag), 32'd0);
    chk("async sat_count", 32'(bs.sat_count), 32'd0);
    chk("async in_ready", 32'(bs.in_ready), 32'd1);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    beat_s(8'h12, 4'd2, 1'b0);
    chk("post-rst dout", 32'(bs.dout), 32'h048);
    chk("post-rst sat", 32'(bs.sat_out), 32'd0);
    chk("post-rst valid", 32'(bs.out_valid), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
